vpu_issue_ctrl: RTL and testbench

VPU_ISSUE_CTRL -- requirements
Module: vpu_issue_ctrl

---
 rtl/vpu_issue_ctrl.sv | 117 +++++++++++
 tb/tb_vpu_issue_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_issue_ctrl.sv
// rtl/vpu_issue_ctrl.sv - vector unit command issue sequencer (read, execute, write-back per element)
module vpu_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_opcode,
    input  logic [ADDR_W-1:0] cmd_src0,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    input  logic [DATA_W-1:0] rd_data0,
    input  logic [DATA_W-1:0] rd_data1,
    output logic              alu_start,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_op0,
    output logic [DATA_W-1:0] alu_op1,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_EX,
        S_WB,
        S_FIN
    } state_t;

    state_t              state;
    logic [OP_W-1:0]     op_q;
    logic [ADDR_W-1:0]   src0_q;
    logic [ADDR_W-1:0]   src1_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    idx;
    logic [DATA_W-1:0]   res_q;
    logic [ADDR_W-1:0]   idx_a;
    logic                cmd_illegal;

    // Element offsets wrap with the buffer address space.
    assign idx_a       = ADDR_W'(idx);
    assign cmd_illegal = cmd_opcode > OP_W'(3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_q   <= '0;
            src0_q <= '0;
            src1_q <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            idx    <= '0;
            res_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_opcode;
                        src0_q <= cmd_src0;
                        src1_q <= cmd_src1;
                        dst_q  <= cmd_dst;
                        len_q  <= cmd_len;
                        idx    <= '0;
                        state  <= (cmd_len == '0 || cmd_illegal) ? S_FIN : S_RD;
                    end
                end
                S_RD: state <= S_EX;
                S_EX: begin
                    res_q <= alu_result;
                    state <= S_WB;
                end
                S_WB: begin
                    if (idx == len_q - LEN_W'(1)) begin
                        state <= S_FIN;
                    end else begin
                        idx   <= idx + LEN_W'(1);
                        state <= S_RD;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight from the state register; operands pass through
    // in EX because buffer data only arrives the cycle after the read.
    assign cmd_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign rd_en      = (state == S_RD);
    assign rd_addr0   = rd_en ? src0_q + idx_a : '0;
    assign rd_addr1   = rd_en ? src1_q + idx_a : '0;
    assign alu_start  = (state == S_EX);
    assign alu_opcode = alu_start ? op_q : '0;
    assign alu_op0    = alu_start ? rd_data0 : '0;
    assign alu_op1    = alu_start ? rd_data1 : '0;
    assign wr_en      = (state == S_WB);
    assign wr_addr    = wr_en ? dst_q + idx_a : '0;
    assign wr_data    = wr_en ? res_q : '0;
    assign done       = (state == S_FIN);
    assign err        = done && (op_q > OP_W'(3));

endmodule

// File: tb/tb_vpu_issue_ctrl.sv
// tb/tb_vpu_issue_ctrl.sv - directed self-checking bench for vpu_issue_ctrl
module tb_vpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [7:0]  cmd_src0, cmd_src1, cmd_dst, cmd_len;
    logic        rd_en;
    logic [7:0]  rd_addr0, rd_addr1;
    logic [31:0] rd_data0, rd_data1;
    logic        alu_start;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_op0, alu_op1, alu_result;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy, done, err;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];

    int          rd_c[$];
    logic [7:0]  rd_a0[$];
    logic [7:0]  rd_a1[$];
    int          wr_c[$];
    logic [7:0]  wr_a[$];
    logic [31:0] wr_d[$];
    logic [31:0] alu_a[$];
    int          done_cyc;
    logic        err_at_done;
    int          stray_err;
    int          zero_viol;
    int          cnt;

    vpu_issue_ctrl #(.DATA_W(32), .OP_W(4), .ADDR_W(8), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_src0(cmd_src0), .cmd_src1(cmd_src1), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_op0(alu_op0), .alu_op1(alu_op1),
        .alu_result(alu_result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Buffer returns data the cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data0 <= mem0[rd_addr0];
            rd_data1 <= mem1[rd_addr1];
        end
    end

    // ALU stand-in: answers only the hand-computed FP32 vectors used here.
    always_comb begin
        alu_result = 32'hDEAD_BEEF;
        case (alu_opcode)
            4'd0: if ((alu_op0 == 32'h3F80_0000 && alu_op1 == 32'h4000_0000) ||
                      (alu_op0 == 32'h4000_0000 && alu_op1 == 32'h3F80_0000))
                      alu_result = 32'h4040_0000;
            4'd1: if (alu_op0 == 32'h4040_0000 && alu_op1 == 32'h3F80_0000)
                      alu_result = 32'h4000_0000;
            4'd2: alu_result = alu_op0[31] ? 32'h0 : alu_op0;
            4'd3: if (alu_op0 == 32'h4000_0000 && alu_op1 == 32'h4040_0000)
                      alu_result = 32'h40C0_0000;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one command, then keeps a junk command offered while busy and
    // logs every strobe by cycle number after the accepting edge.
    task automatic run_cmd(input logic [3:0] op, input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] d, input logic [7:0] len, input int abort_at);
        rd_c.delete(); rd_a0.delete(); rd_a1.delete();
        wr_c.delete(); wr_a.delete(); wr_d.delete(); alu_a.delete();
        done_cyc = -1; err_at_done = 1'b0; stray_err = 0; zero_viol = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = op; cmd_src0 = s0; cmd_src1 = s1;
        cmd_dst = d; cmd_len = len;
        @(posedge clk);
        #1;
        cmd_opcode = 4'd0; cmd_src0 = 8'hAA; cmd_src1 = 8'hBB; cmd_dst = 8'hCC; cmd_len = 8'd9;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (rd_en) begin
                rd_c.push_back(k); rd_a0.push_back(rd_addr0); rd_a1.push_back(rd_addr1);
            end else if (rd_addr0 !== 8'h0 || rd_addr1 !== 8'h0) zero_viol++;
            if (wr_en) begin
                wr_c.push_back(k); wr_a.push_back(wr_addr); wr_d.push_back(wr_data);
            end else if (wr_addr !== 8'h0 || wr_data !== 32'h0) zero_viol++;
            if (alu_start) alu_a.push_back(alu_op0);
            else if (alu_op0 !== 32'h0 || alu_op1 !== 32'h0) zero_viol++;
            if (cmd_ready || !busy) zero_viol++;
            if (err && !done) stray_err++;
            if (k == abort_at) break;
            if (done) begin
                done_cyc = k; err_at_done = err; cmd_valid = 1'b0;
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) begin
            mem0[a] = 32'h0;
            mem1[a] = 32'h0;
        end
        mem0[8'h10] = 32'h3F80_0000; mem0[8'h11] = 32'h4000_0000;
        mem1[8'h20] = 32'h4000_0000; mem1[8'h21] = 32'h3F80_0000;
        mem0[8'h40] = 32'h4040_0000; mem1[8'h50] = 32'h3F80_0000;
        mem0[8'h41] = 32'h4000_0000; mem1[8'h51] = 32'h4040_0000;
        mem0[8'h70] = 32'hBF80_0000; mem0[8'h71] = 32'h4000_0000;
        mem1[8'h80] = 32'h1234_5678; mem1[8'h81] = 32'h8765_4321;
        mem0[8'hFF] = 32'h4000_0000; mem0[8'h00] = 32'h3F80_0000;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = 4'd0;
        cmd_src0 = 8'h0; cmd_src1 = 8'h0; cmd_dst = 8'h0; cmd_len = 8'h0;
        #2;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobes", {28'h0, rd_en, alu_start, wr_en, done}, 32'h0);
        check("rst_err", 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // ADD len=2
        run_cmd(4'd0, 8'h10, 8'h20, 8'h30, 8'd2, 0);
        check("add_rd_count", 32'(rd_c.size()), 32'd2);
        check("add_rd0_cyc", 32'(rd_c[0]), 32'd1);
        check("add_rd1_cyc", 32'(rd_c[1]), 32'd4);
        check("add_rd_addr0", {rd_a0[0], rd_a0[1]}, 32'h1011);
        check("add_rd_addr1", {rd_a1[0], rd_a1[1]}, 32'h2021);
        check("add_alu_op0", alu_a[1], 32'h4000_0000);
        check("add_wr_count", 32'(wr_c.size()), 32'd2);
        check("add_wr_cyc", 32'((wr_c[0] << 8) | wr_c[1]), 32'h0306);
        check("add_wr_addr", {wr_a[0], wr_a[1]}, 32'h3031);
        check("add_wr_data0", wr_d[0], 32'h4040_0000);
        check("add_wr_data1", wr_d[1], 32'h4040_0000);
        check("add_done_cyc", 32'(done_cyc), 32'd7);
        check("add_err", 32'(err_at_done), 32'd0);
        check("add_idle_zero", 32'(zero_viol), 32'd0);

        // SUB and MUL, len=1
        run_cmd(4'd1, 8'h40, 8'h50, 8'h60, 8'd1, 0);
        check("sub_wr_data", wr_d[0], 32'h4000_0000);
        check("sub_wr_addr", 32'(wr_a[0]), 32'h60);
        check("sub_done_cyc", 32'(done_cyc), 32'd4);
        run_cmd(4'd3, 8'h41, 8'h51, 8'h61, 8'd1, 0);
        check("mul_wr_data", wr_d[0], 32'h40C0_0000);
        check("mul_done_cyc", 32'(done_cyc), 32'd4);

        // RELU len=2
        run_cmd(4'd2, 8'h70, 8'h80, 8'h90, 8'd2, 0);
        check("relu_wr_data0", wr_d[0], 32'h0);
        check("relu_wr_data1", wr_d[1], 32'h4000_0000);
        check("relu_rd_addr1", {rd_a1[0], rd_a1[1]}, 32'h8081);
        check("relu_idle_zero", 32'(zero_viol), 32'd0);

        // Address wrap at 0xFF
        run_cmd(4'd2, 8'hFF, 8'h05, 8'hFF, 8'd2, 0);
        check("wrap_rd_addr0", {rd_a0[0], rd_a0[1]}, 32'hFF00);
        check("wrap_wr_addr", {wr_a[0], wr_a[1]}, 32'hFF00);
        check("wrap_wr_data1", wr_d[1], 32'h3F80_0000);
        check("wrap_done_cyc", 32'(done_cyc), 32'd7);

        // len=0 and illegal opcode
        run_cmd(4'd0, 8'h10, 8'h20, 8'h30, 8'd0, 0);
        check("len0_done_cyc", 32'(done_cyc), 32'd1);
        check("len0_err", 32'(err_at_done), 32'd0);
        check("len0_no_rw", 32'(rd_c.size() + wr_c.size() + alu_a.size()), 32'd0);
        run_cmd(4'd5, 8'h10, 8'h20, 8'h30, 8'd3, 0);
        check("badop_done_cyc", 32'(done_cyc), 32'd1);
        check("badop_err", 32'(err_at_done), 32'd1);
        check("badop_no_rw", 32'(rd_c.size() + wr_c.size() + alu_a.size()), 32'd0);
        check("err_stray", 32'(stray_err), 32'd0);

        // Reset during EX of element 1 of a len=4 ADD
        run_cmd(4'd0, 8'h10, 8'h20, 8'h30, 8'd4, 5);
        check("abort_in_ex", 32'(alu_start), 32'd1);
        check("abort_wr_before", 32'(wr_c.size()), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_outputs_zero",
              {26'h0, rd_en, alu_start, wr_en, done, err, busy}, 32'h0);
        check("abort_alu_op0", alu_op0, 32'h0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (wr_en || done) cnt++;
        end
        check("abort_no_wr_done", 32'(cnt), 32'd0);
        run_cmd(4'd1, 8'h40, 8'h50, 8'h62, 8'd1, 0);
        check("post_rst_wr_data", wr_d[0], 32'h4000_0000);
        check("post_rst_wr_addr", 32'(wr_a[0]), 32'h62);
        check("post_rst_done_cyc", 32'(done_cyc), 32'd4);

        @(negedge clk);
        check("final_idle", {30'h0, cmd_ready, busy}, 32'h2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
